// File: rtl/cpu_run_controller.sv
// cpu_run_controller
//   Run harness for the pipelined in-memory-computing CPU. It first streams a
//   program into instruction memory. It then releases the datapath and runs it
//   until a HALT fetch or a cycle limit is reached. After a HALT it drains the
//   pipeline for PIPE_DEPTH cycles. It reports cycle, instruction and
//   in-memory-op counts.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   start, prog_len,         launch a load+run; prog_len = 0 skips the load,
//   run_limit                run_limit = 0 means the run is unlimited
//   s_valid/s_data/s_ready   program word stream (valid/ready)
//   imem_we/addr/wdata       instruction memory write port (combinational)
//   cpu_rst, cpu_en          datapath reset and clock enable
//   fetch_valid/fetch_instr  IF-stage fetch observation
//   busy, done, timeout      status: LOAD/RUN/DRAIN, run finished, ended by limit
//   cycle/instr/imc_count    saturating run statistics
module cpu_run_controller #(
  parameter int         INSTR_WIDTH = 16,
  parameter int         ADDR_WIDTH  = 10,
  parameter int         CYC_WIDTH   = 16,
  parameter int         OPC_MSB     = 15,
  parameter logic [2:0] HALT_OPC    = 3'b111,
  parameter logic [2:0] IMC_OPC     = 3'b001,
  parameter int         PIPE_DEPTH  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  prog_len,
  input  logic [CYC_WIDTH-1:0]   run_limit,
  input  logic                   s_valid,
  input  logic [INSTR_WIDTH-1:0] s_data,
  output logic                   s_ready,
  output logic                   imem_we,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   cpu_rst,
  output logic                   cpu_en,
  input  logic                   fetch_valid,
  input  logic [INSTR_WIDTH-1:0] fetch_instr,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic [CYC_WIDTH-1:0]   cycle_count,
  output logic [CYC_WIDTH-1:0]   instr_count,
  output logic [CYC_WIDTH-1:0]   imc_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int DRAIN_W = $clog2(PIPE_DEPTH + 1);

  logic [2:0]             state_q,   state_d;
  logic [ADDR_WIDTH-1:0]  ptr_q,     ptr_d;
  logic [ADDR_WIDTH-1:0]  len_q,     len_d;
  logic [CYC_WIDTH-1:0]   limit_q,   limit_d;
  logic [DRAIN_W-1:0]     drain_q,   drain_d;
  logic [CYC_WIDTH-1:0]   cycle_q,   cycle_d;
  logic [CYC_WIDTH-1:0]   instr_q,   instr_d;
  logic [CYC_WIDTH-1:0]   imc_q,     imc_d;
  logic                   timeout_q, timeout_d;
  logic                   s_ready_q, s_ready_d;
  logic                   cpu_rst_q, cpu_rst_d;
  logic                   cpu_en_q,  cpu_en_d;
  logic                   busy_q,    busy_d;
  logic                   done_q,    done_d;

  logic       handshake;
  logic [2:0] fetch_opc;

  // The counters stick at all-ones instead of wrapping.
  function automatic logic [CYC_WIDTH-1:0] sat_inc(input logic [CYC_WIDTH-1:0] v);
    return (&v) ? v : v + CYC_WIDTH'(1);
  endfunction

  assign handshake = (state_q == S_LOAD) && s_valid && s_ready_q;
  assign fetch_opc = fetch_instr[OPC_MSB -: 3];

  // The write port is combinational, so a word is written in the same
  // cycle as its handshake.
  assign imem_we    = handshake;
  assign imem_addr  = handshake ? ptr_q  : '0;
  assign imem_wdata = handshake ? s_data : '0;

  always_comb begin
    // NOTE: every variable gets a default before the case statement. A path
    // that leaves a variable unassigned in combinational logic infers a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    limit_d   = limit_q;
    drain_d   = drain_q;
    cycle_d   = cycle_q;
    instr_d   = instr_q;
    imc_d     = imc_q;
    timeout_d = timeout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_d     = prog_len;
          limit_d   = run_limit;
          ptr_d     = '0;
          cycle_d   = '0;
          instr_d   = '0;
          imc_d     = '0;
          timeout_d = 1'b0;
          state_d   = (prog_len != '0) ? S_LOAD : S_RUN;
        end
      end
      S_LOAD: begin
        if (handshake) begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
          if (ptr_q == len_q - ADDR_WIDTH'(1)) state_d = S_RUN;
        end
      end
      S_RUN: begin
        cycle_d = sat_inc(cycle_q);
        if (fetch_valid) begin
          instr_d = sat_inc(instr_q);
          if (fetch_opc == IMC_OPC) imc_d = sat_inc(imc_q);
        end
        // HALT takes priority over the limit when both happen in one cycle.
        if (fetch_valid && fetch_opc == HALT_OPC) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_W'(PIPE_DEPTH);
        end else if (limit_q != '0 && cycle_d == limit_q) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DRAIN: begin
        cycle_d = sat_inc(cycle_q);
        drain_d = drain_q - DRAIN_W'(1);
        if (drain_q == DRAIN_W'(1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // The status outputs are registered from the next state, so they line up
    // with the state register.
    s_ready_d = (state_d == S_LOAD);
    cpu_en_d  = (state_d == S_RUN) || (state_d == S_DRAIN);
    cpu_rst_d = !cpu_en_d;
    busy_d    = (state_d == S_LOAD) || cpu_en_d;
    done_d    = (state_d == S_DONE);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      len_q     <= '0;
      limit_q   <= '0;
      drain_q   <= '0;
      cycle_q   <= '0;
      instr_q   <= '0;
      imc_q     <= '0;
      timeout_q <= 1'b0;
      s_ready_q <= 1'b0;
      cpu_rst_q <= 1'b1;
      cpu_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      len_q     <= len_d;
      limit_q   <= limit_d;
      drain_q   <= drain_d;
      cycle_q   <= cycle_d;
      instr_q   <= instr_d;
      imc_q     <= imc_d;
      timeout_q <= timeout_d;
      s_ready_q <= s_ready_d;
      cpu_rst_q <= cpu_rst_d;
      cpu_en_q  <= cpu_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign cpu_rst     = cpu_rst_q;
  assign cpu_en      = cpu_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
  assign imc_count   = imc_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller
//   Directed bench for cpu_run_controller. A default-parameter instance covers
//   reset, program load, HALT run with drain, timeout, same-cycle HALT/limit,
//   prog_len=0 and restart from DONE. A second instance with CYC_WIDTH=4
//   shares the stimulus and covers counter saturation.
module tb_cpu_run_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  prog_len;
  logic [15:0] run_limit;
  logic [3:0]  run_limit4;
  logic        s_valid;
  logic [15:0] s_data;
  logic        fetch_valid;
  logic [15:0] fetch_instr;

  logic        s_ready, imem_we, cpu_rst, cpu_en, busy, done, timeout;
  logic [9:0]  imem_addr;
  logic [15:0] imem_wdata, cycle_count, instr_count, imc_count;

  logic        s_ready_s, imem_we_s, cpu_rst_s, cpu_en_s, busy_s, done_s, timeout_s;
  logic [9:0]  imem_addr_s;
  logic [15:0] imem_wdata_s;
  logic [3:0]  cycle_count_s, instr_count_s, imc_count_s;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  cpu_run_controller dut (
    .clk(clk), .rst(rst), .start(start), .prog_len(prog_len), .run_limit(run_limit),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .cpu_en(cpu_en),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .busy(busy), .done(done), .timeout(timeout),
    .cycle_count(cycle_count), .instr_count(instr_count), .imc_count(imc_count)
  );

  cpu_run_controller #(.CYC_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .prog_len(prog_len), .run_limit(run_limit4),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_s),
    .imem_we(imem_we_s), .imem_addr(imem_addr_s), .imem_wdata(imem_wdata_s),
    .cpu_rst(cpu_rst_s), .cpu_en(cpu_en_s),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .busy(busy_s), .done(done_s), .timeout(timeout_s),
    .cycle_count(cycle_count_s), .instr_count(instr_count_s), .imc_count(imc_count_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge, where registered outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] vpat;
    logic [2:0] ops [5];
    int         we_cnt;
    int         k;

    vpat   = 6'b101101;  // s_valid pattern 1,0,1,1,0,1 read from bit 0 upward
    ops[0] = 3'b001; ops[1] = 3'b010; ops[2] = 3'b001; ops[3] = 3'b100; ops[4] = 3'b111;

    rst = 1'b1; start = 1'b0; prog_len = '0; run_limit = '0; run_limit4 = '0;
    s_valid = 1'b0; s_data = '0; fetch_valid = 1'b0; fetch_instr = '0;

    // Reset: hold rst for two cycles.
    step(); step();
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_cpu_en",  cpu_en,  0);
    check("rst_s_ready", s_ready, 0);
    check("rst_busy",    busy,    0);
    check("rst_done",    done,    0);
    check("rst_timeout", timeout, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_cycle",   cycle_count, 0);
    check("rst_instr",   instr_count, 0);
    check("rst_imc",     imc_count,   0);

    // Load four words with a gapped s_valid.
    rst = 1'b0; step();
    prog_len = 10'd4; start = 1'b1;
    step();
    start = 1'b0;
    check("load_busy",    busy,    1);
    check("load_cpu_rst", cpu_rst, 1);
    we_cnt = 0; k = 0;
    for (int i = 0; i < 6; i++) begin
      s_valid = vpat[i];
      s_data  = 16'hA000 + 16'(i);
      #1;
      check("load_s_ready", s_ready, 1);
      check("load_we", imem_we, vpat[i]);
      if (imem_we) we_cnt++;
      if (vpat[i]) begin
        check("load_addr",  imem_addr,  k);
        check("load_wdata", imem_wdata, 32'hA000 + i);
        k++;
      end else begin
        check("load_wdata_idle", imem_wdata, 0);
      end
      step();
    end
    s_valid = 1'b0;
    check("load_we_count", we_cnt, 4);
    check("load_s_ready_drop", s_ready, 0);
    check("run_cpu_rst", cpu_rst, 0);
    check("run_cpu_en",  cpu_en,  1);

    // HALT run: fetch 001,010,001,100,111 from the first RUN cycle.
    for (int i = 0; i < 5; i++) begin
      fetch_valid = 1'b1;
      fetch_instr = {ops[i], 13'h0};
      step();
    end
    check("halt_busy",  busy, 1);
    check("halt_instr", instr_count, 5);
    check("halt_imc",   imc_count,   2);
    check("halt_cycle", cycle_count, 5);
    // Fetches during DRAIN must not be counted.
    fetch_instr = {3'b001, 13'h0};
    step();
    check("drain1_done", done, 0);
    step();
    check("drain2_done", done, 0);
    check("drain2_en",   cpu_en, 1);
    step();
    fetch_valid = 1'b0;
    check("halt_done",    done,    1);
    check("halt_timeout", timeout, 0);
    check("halt_cycle8",  cycle_count, 8);
    check("halt_instr5",  instr_count, 5);
    check("halt_imc2",    imc_count,   2);
    check("halt_cpu_en",  cpu_en,  0);
    check("halt_cpu_rst", cpu_rst, 1);
    check("halt_busy0",   busy,    0);

    // Restart from DONE with prog_len=0 and run_limit=10; s_valid high must not write.
    prog_len = '0; run_limit = 16'd10; start = 1'b1; s_valid = 1'b1; s_data = 16'h5555;
    #1;
    check("done_no_we", imem_we, 0);
    step();
    start = 1'b0;
    check("rerun_cycle_clr", cycle_count, 0);
    check("rerun_instr_clr", instr_count, 0);
    check("rerun_done_clr",  done,  0);
    check("rerun_cpu_en",    cpu_en, 1);
    check("rerun_no_we",     imem_we, 0);
    for (int c = 1; c <= 10; c++) begin
      start = (c == 3);  // start while busy is ignored
      step();
      start = 1'b0;
      check("to_cycle",   cycle_count, c);
      check("to_timeout", timeout, (c == 10) ? 1 : 0);
    end
    s_valid = 1'b0;
    check("to_done",   done,   1);
    check("to_cpu_en", cpu_en, 0);
    check("to_busy",   busy,   0);

    // Reset in the middle of a load, after 2 of 4 words.
    prog_len = 10'd4; start = 1'b1;
    step();
    start = 1'b0; s_valid = 1'b1;
    step(); step();
    check("mid_we_before_rst", imem_we, 1);
    check("mid_addr2", imem_addr, 2);
    rst = 1'b1;
    step();
    check("mid_rst_we",      imem_we, 0);
    check("mid_rst_s_ready", s_ready, 0);
    check("mid_rst_cpu_rst", cpu_rst, 1);
    check("mid_rst_busy",    busy,    0);
    check("mid_rst_cycle",   cycle_count, 0);
    check("mid_rst_sat_busy", busy_s, 0);
    step();
    rst = 1'b0;
    step();
    check("mid_idle_we",   imem_we, 0);
    check("mid_idle_busy", busy,    0);
    s_valid = 1'b0;

    // HALT fetched in the same cycle the limit (3) is reached.
    prog_len = '0; run_limit = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    fetch_valid = 1'b1; fetch_instr = {3'b111, 13'h0};
    step();
    fetch_valid = 1'b0;
    check("tie_busy",    busy,    1);
    check("tie_timeout", timeout, 0);
    check("tie_done",    done,    0);
    check("tie_cycle",   cycle_count, 3);
    step(); step(); step();
    check("tie_done_end",    done,    1);
    check("tie_timeout_end", timeout, 0);
    check("tie_cycle_end",   cycle_count, 6);

    // Saturation: both instances run unlimited with 20 fetches of 001.
    run_limit = '0; run_limit4 = '0; start = 1'b1;
    step();
    start = 1'b0;
    fetch_valid = 1'b1; fetch_instr = {3'b001, 13'h0};
    repeat (20) step();
    check("sat_instr", instr_count_s, 15);
    check("sat_imc",   imc_count_s,   15);
    check("sat_cycle", cycle_count_s, 15);
    check("sat_busy",  busy_s, 1);
    check("wide_instr", instr_count, 20);
    check("wide_cycle", cycle_count, 20);
    step();
    check("sat_hold_instr", instr_count_s, 15);
    check("sat_hold_cycle", cycle_count_s, 15);
    fetch_valid = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
